vec_mem_seq: RTL and testbench
==============================

// Module: vec_mem_seq
// PURPOSE
//  Parametrised vector load/store sequencer for the vector datapath. Moves up to
//  LANES elements of WIDTH bits between a flat vector-register bus and single-word
//  system memory (Addr/RD/WR/DataIn/DataOut), one element per cycle, with a
//  programmable base, stride and element count. Replaces hand-sequenced per-word
//  memory access in the controller with a Start/Busy/Done handshake.
// PARAMETERS
//  WIDTH  16  element and memory word width, bits
//  LANES  16  vector length (elements per register), >=1
//  AW     16  memory address width, bits
//  LW      5  width of Len; must hold LANES (clog2(LANES+1))
// PORTS
//  Clk      in   1            single system clock, all logic on posedge
//  Reset_n  in   1            synchronous reset, active-low
//  Start    in   1            request; sampled only in IDLE or DONE
//  Op       in   1            0 = load (mem->VecOut), 1 = store (VecIn->mem)
//  Base     in   AW           address of element 0
//  Stride   in   AW           address increment per element (modulo 2^AW)
//  Len      in   LW           element count; values >LANES clamp to LANES
//  VecIn    in   WIDTH*LANES  store source; lane i = VecIn[i*WIDTH +: WIDTH]
//  VecOut   out  WIDTH*LANES  load result, same lane packing
//  Busy     out  1            high in RUN and DRAIN
//  Done     out  1            one-cycle pulse in DONE
//  Addr     out  AW           memory address, registered
//  RD       out  1            memory read strobe, registered
//  WR       out  1            memory write strobe, registered
//  DataOut  out  WIDTH        memory write data, registered
//  DataIn   in   WIDTH        memory read data, valid the cycle after RD
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge): state IDLE; Busy, Done, RD, WR = 0; Addr, DataOut,
//   VecOut = 0; element counter = 0. Applies mid-operation: transfer aborted, no
//   Done, outstanding read data dropped.
//  States: IDLE, RUN, DRAIN, DONE. Edge E0 = posedge at which Start=1 is sampled.
//  At E0: latch Op, Base, Stride, N=min(Len,LANES); store also latches VecIn into a
//   shadow register (later VecIn changes ignored); load clears VecOut to 0.
//  N=0: IDLE/DONE -> DONE at E0; no RD/WR ever asserted; Done pulses.
//  RUN: cycle after E_i (i=0..N-1) drives Addr=Base+i*Stride (mod 2^AW, wraps
//   silently), and RD=1 (load) or WR=1 + DataOut=shadow lane i (store).
//   Address produced by accumulator (add Stride per element), no multiplier.
//  Load capture: DataIn sampled at E_{i+2} into VecOut lane i. Lanes >= N stay 0.
//  Store: RUN -> DONE at E_N. Done high in cycle after E_N (latency N+1).
//  Load: RUN -> DRAIN at E_N (RD=0, lane N-1 captured at E_{N+1}); DRAIN -> DONE at
//   E_{N+1}. Done high in cycle after E_{N+1} (latency N+2).
//  RD and WR never high together; both low in IDLE, DRAIN, DONE.
//  DONE: Done=1, Busy=0 for exactly one cycle; -> RUN/DONE if Start=1 (back-to-back,
//   no idle cycle), else -> IDLE. VecOut holds until next load Start or reset.
//  Start while Busy: ignored, latched config unaffected, no error flag.
// TESTING
//  Reset: Reset_n=0 two cycles -> all outputs 0, state IDLE, Busy=0.
//  Store Len=4 Base=0x0100 Stride=2, VecIn lanes 0..3=A0..A3 -> WR on 4 consecutive
//   cycles, Addr 0x0100/0102/0104/0106, DataOut A0..A3, Done pulse at latency 5.
//  Load Len=16 Base=0xFFFE Stride=1, memory model returns Addr^0x5A5A -> Addr wraps
//   FFFE,FFFF,0000..000D; VecOut lane i = addr_i^0x5A5A; Done at latency 18.
//  Len=0 (and Len=31 with LANES=16) -> immediate Done, no strobes; clamped run moves
//   exactly 16 elements.
//  Start pulsed during RUN with different Base -> ignored; addresses unchanged.
//  Reset_n=0 at element 5 of 8-element load -> strobes low next cycle, VecOut 0,
//   no Done; following load with Done back-to-back Start -> second op begins in
//   the cycle after Done with no gap.

Source files
------------

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves up to LANES elements between a flat vector bus and word memory.
// Latency N+1 (store) / N+2 (load) from Start to Done; Start is ignored while Busy, no other backpressure.
module vec_mem_seq #(
  parameter int WIDTH = 16,
  parameter int LANES = 16,
  parameter int AW    = 16,
  parameter int LW    = 5
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Start,
  input  logic                   Op,
  input  logic [AW-1:0]          Base,
  input  logic [AW-1:0]          Stride,
  input  logic [LW-1:0]          Len,
  input  logic [WIDTH*LANES-1:0] VecIn,
  output logic [WIDTH*LANES-1:0] VecOut,
  output logic                   Busy,
  output logic                   Done,
  output logic [AW-1:0]          Addr,
  output logic                   RD,
  output logic                   WR,
  output logic [WIDTH-1:0]       DataOut,
  input  logic [WIDTH-1:0]       DataIn
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [LW-1:0] LANES_W = LW'(LANES);

  state_t                 state, state_nxt;
  logic [LW-1:0]          len_n, n_q, cnt, rd_idx, cap_idx;
  logic                   op_q, cap_vld, accept, more;
  logic [AW-1:0]          stride_q;
  logic [WIDTH*LANES-1:0] shadow;

  assign len_n  = (Len > LANES_W) ? LANES_W : Len;
  assign accept = Start && (state == IDLE || state == DONE);
  assign more   = (state == RUN) && (cnt != n_q);

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (Start)             state_nxt = (len_n == '0) ? DONE : RUN;
        else                   state_nxt = IDLE;
      end
      RUN:   if (cnt == n_q)   state_nxt = op_q ? DONE : DRAIN;
      DRAIN:                   state_nxt = DONE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN) || (state == DRAIN);
    Done = (state == DONE);
  end

  // Read data arrives one cycle after RD, so the lane index rides a one-stage pipe to meet it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      VecOut   <= '0;
      Addr     <= '0;
      RD       <= 1'b0;
      WR       <= 1'b0;
      DataOut  <= '0;
      cnt      <= '0;
      n_q      <= '0;
      op_q     <= 1'b0;
      stride_q <= '0;
      shadow   <= '0;
      rd_idx   <= '0;
      cap_idx  <= '0;
      cap_vld  <= 1'b0;
    end else begin
      RD      <= 1'b0;
      WR      <= 1'b0;
      cap_vld <= RD;
      cap_idx <= rd_idx;
      if (cap_vld) VecOut[int'(cap_idx)*WIDTH +: WIDTH] <= DataIn;

      if (accept) begin
        op_q     <= Op;
        stride_q <= Stride;
        n_q      <= len_n;
        cnt      <= '0;
        if (Op)  shadow <= VecIn;
        else     VecOut <= '0;
        if (len_n != '0) begin
          Addr   <= Base;
          RD     <= !Op;
          WR     <= Op;
          rd_idx <= '0;
          cnt    <= LW'(1);
          if (Op) DataOut <= VecIn[WIDTH-1:0];
        end
      end else if (more) begin
        // Address accumulates by Stride each element and wraps modulo 2^AW.
        Addr   <= Addr + stride_q;
        RD     <= !op_q;
        WR     <= op_q;
        rd_idx <= cnt;
        cnt    <= cnt + LW'(1);
        if (op_q) DataOut <= shadow[int'(cnt)*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Bench for vec_mem_seq: directed ops push expected strobes/Done into a queue, a negedge monitor pops and compares.
module tb_vec_mem_seq;

  typedef struct {
    int           kind;   // 0 read strobe, 1 write strobe, 2 done
    logic [15:0]  addr;
    logic [15:0]  data;
    int           rel;    // cycles after Start edge, cycle after E0 = 1
    bit           chk_vec;
    logic [255:0] vec;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset_n, Start, Op;
  logic [15:0]  Base, Stride;
  logic [4:0]   Len;
  logic [255:0] VecIn, VecOut;
  logic         Busy, Done, RD, WR;
  logic [15:0]  Addr, DataOut;
  logic [15:0]  DataIn = '0;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   e0_cyc = 0;

  vec_mem_seq #(.WIDTH(16), .LANES(16), .AW(16), .LW(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .Base(Base), .Stride(Stride),
    .Len(Len), .VecIn(VecIn), .VecOut(VecOut), .Busy(Busy), .Done(Done), .Addr(Addr),
    .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  // Memory returns Addr^0x5A5A in the cycle after RD.
  always @(posedge Clk) if (RD) DataIn <= Addr ^ 16'h5A5A;

  function automatic void check(string name, logic [255:0] got, logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (RD || WR) begin
      check("rd_wr_excl", 256'(RD & WR), 256'(0));
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe got addr=%0h want none", Addr);
      end else begin
        e = q.pop_front();
        check("strobe_kind", 256'(WR ? 1 : 0), 256'(e.kind));
        check("addr", 256'(Addr), 256'(e.addr));
        check("strobe_time", 256'(cyc - e0_cyc + 1), 256'(e.rel));
        if (e.kind == 1) check("data_out", 256'(DataOut), 256'(e.data));
      end
    end
    if (Done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done got done=1 want none");
      end else begin
        e = q.pop_front();
        check("done_kind", 256'(2), 256'(e.kind));
        check("done_latency", 256'(cyc - e0_cyc + 1), 256'(e.rel));
        check("busy_in_done", 256'(Busy), 256'(0));
        if (e.chk_vec) check("vec_out", VecOut, e.vec);
      end
    end
  end

  // keep < 0: full op with Done; keep >= 0: only the first keep strobes are expected.
  task automatic issue(input bit op, input logic [15:0] base, input logic [15:0] stride,
                       input logic [4:0] len, input logic [255:0] vin, input int keep);
    exp_t e;
    logic [15:0]  a;
    logic [255:0] v;
    int n, lim;
    n   = (len > 5'd16) ? 16 : int'(len);
    lim = (keep < 0) ? n : keep;
    a   = base;
    v   = '0;
    for (int i = 0; i < n; i++) begin
      if (i < lim) begin
        e.kind = int'(op); e.addr = a; e.data = vin[i*16 +: 16];
        e.rel = i + 1; e.chk_vec = 1'b0; e.vec = '0;
        q.push_back(e);
      end
      v[i*16 +: 16] = a ^ 16'h5A5A;
      a = a + stride;
    end
    if (keep < 0) begin
      e.kind = 2; e.addr = '0; e.data = '0;
      e.rel = (n == 0) ? 1 : (op ? n + 1 : n + 2);
      e.chk_vec = !op; e.vec = v;
      q.push_back(e);
    end
    Op = op; Base = base; Stride = stride; Len = len; VecIn = vin; Start = 1'b1;
    @(posedge Clk);
    #1;
    e0_cyc = cyc;
    Start  = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (Done) break;
    end
    if (k == 200) begin
      total++; bad++;
      $display("FAIL done_timeout got no done want done within 200 cycles");
    end
  endtask

  initial begin
    logic [255:0] v;
    Reset_n = 1'b0; Start = 1'b0; Op = 1'b0; Base = '0; Stride = '0; Len = '0; VecIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", 256'(Busy), 256'(0));
    check("rst_done", 256'(Done), 256'(0));
    check("rst_rd", 256'(RD), 256'(0));
    check("rst_wr", 256'(WR), 256'(0));
    check("rst_addr", 256'(Addr), 256'(0));
    check("rst_dout", 256'(DataOut), 256'(0));
    check("rst_vec", VecOut, 256'(0));
    @(negedge Clk) Reset_n = 1'b1;
    @(negedge Clk);

    // Store 4 elements; VecIn changed after E0 must not leak into DataOut.
    v = '1;
    v[15:0] = 16'hA000; v[31:16] = 16'hA111; v[47:32] = 16'hA222; v[63:48] = 16'hA333;
    issue(1'b1, 16'h0100, 16'h0002, 5'd4, v, -1);
    VecIn = '0;
    wait_done();
    @(negedge Clk);

    // 16-element load across the address wrap.
    issue(1'b0, 16'hFFFE, 16'h0001, 5'd16, '0, -1);
    wait_done();
    @(negedge Clk);

    // Len=0 load: immediate Done, VecOut cleared.
    issue(1'b0, 16'h0500, 16'h0001, 5'd0, '0, -1);
    wait_done();
    @(negedge Clk);

    // Len=31 clamps to 16 elements.
    issue(1'b0, 16'h0040, 16'h0003, 5'd31, '0, -1);
    wait_done();
    @(negedge Clk);

    // Start pulsed mid-run with a different Base/Op must be ignored.
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h1000 + 16'(i);
    issue(1'b1, 16'h2000, 16'h0010, 5'd8, v, -1);
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b1; Base = 16'h9000; Op = 1'b0; Len = 5'd2;
    @(negedge Clk) Start = 1'b0;
    wait_done();
    @(negedge Clk);

    // Reset sampled at E5 of an 8-element load: 5 reads seen, then silence, no Done.
    issue(1'b0, 16'h3000, 16'h0004, 5'd8, '0, 5);
    repeat (4) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    check("abort_rd", 256'(RD), 256'(0));
    check("abort_wr", 256'(WR), 256'(0));
    check("abort_vec", VecOut, 256'(0));
    check("abort_busy", 256'(Busy), 256'(0));
    check("abort_queue", 256'(q.size()), 256'(0));
    @(negedge Clk) Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    // Back-to-back: load, store started in the Done cycle, then Len=0 from DONE.
    issue(1'b0, 16'h1234, 16'hFFFF, 5'd3, '0, -1);
    wait_done();
    issue(1'b1, 16'h0800, 16'h0100, 5'd2, v, -1);
    wait_done();
    issue(1'b1, 16'h0000, 16'h0001, 5'd0, v, -1);
    wait_done();

    repeat (5) @(negedge Clk);
    check("queue_empty", 256'(q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
